// File: rtl/hex_word_drawer_pkg.sv
// Shared types, constants and glyph data for the hex word drawer.
package hex_word_drawer_pkg;

    localparam int HEX_LATENCY    = 3;
    localparam int HEX_AREA_MAX_Y = 384;
    localparam int GLYPH_W        = 8;
    localparam int GLYPH_H        = 8;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t HEX_FG_RGB = 8'hFF;
    localparam rgb332_t HEX_HL_RGB = 8'hE0;

    // Per-pixel side information that travels alongside the RAM fetch.
    typedef struct packed {
        logic       in_hex;
        logic [1:0] digit;
        logic [2:0] gx;
        logic [2:0] gy;
        logic       hl;
    } hex_pipe_t;

    // 8x8 glyphs, row 0 in the top byte, column 0 in bit 7.
    // Column 0 and row 7 stay blank so adjacent digits do not touch.
    function automatic logic [GLYPH_W*GLYPH_H-1:0] glyph_bits(input logic [3:0] nib);
        logic [GLYPH_W*GLYPH_H-1:0] g;
        case (nib)
            4'h0:    g = 64'h1C22262A32221C00;
            4'h1:    g = 64'h0818080808081C00;
            4'h2:    g = 64'h1C22020408103E00;
            4'h3:    g = 64'h3C02021C02023C00;
            4'h4:    g = 64'h040C14243E040400;
            4'h5:    g = 64'h3E203C0202221C00;
            4'h6:    g = 64'h1C20203C22221C00;
            4'h7:    g = 64'h3E02040810101000;
            4'h8:    g = 64'h1C22221C22221C00;
            4'h9:    g = 64'h1C22221E02021C00;
            4'hA:    g = 64'h1C22223E22222200;
            4'hB:    g = 64'h3C22223C22223C00;
            4'hC:    g = 64'h1C22202020221C00;
            4'hD:    g = 64'h3C22222222223C00;
            4'hE:    g = 64'h3E20203C20203E00;
            default: g = 64'h3E20203C20202000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_word_drawer_if.sv
// Pixel-position, RAM read port and colour-output bundle of the hex word drawer.
// master = the drawer itself, slave = sync_gen / RAM / colour-mux side.
interface hex_word_drawer_if
    import hex_word_drawer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_WIDTH  = 16
) ();

    logic [9:0]            pixel_x;
    logic [9:0]            pixel_y;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [RAM_WIDTH-1:0]  mem_rd_data;
    logic [ADDR_WIDTH-1:0] cursor_addr;
    logic                  number_drawing_request;
    rgb332_t               number_rgb;

    modport master (
        input  pixel_x, pixel_y, mem_rd_data, cursor_addr,
        output mem_addr, mem_rd_en, number_drawing_request, number_rgb
    );

    modport slave (
        output pixel_x, pixel_y, mem_rd_data, cursor_addr,
        input  mem_addr, mem_rd_en, number_drawing_request, number_rgb
    );

endinterface

// File: rtl/hex_word_drawer_font_rom.sv
// Combinational 16-glyph hex font: returns one 8-pixel row of a digit.
module hex_font_rom
    import hex_word_drawer_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic [2:0] row_i,
    output logic [7:0] row_bits_o
);

    logic [63:0] glyph;

    // Select the glyph, then pick its row (row 0 lives in the top byte).
    always_comb begin
        glyph      = glyph_bits(nibble_i);
        row_bits_o = glyph[{~row_i, 3'b000} +: 8];
    end

endmodule

// File: rtl/hex_word_drawer.sv
// Hex column renderer: pixel -> RAM word/digit -> glyph pixel, 3 clocks behind pixel_x/pixel_y.
// Optional build macro HEX_DRAWER_HIGHLIGHT_EN draws the word at cursor_addr inverted.
module hex_word_drawer
    import hex_word_drawer_pkg::*;
#(
    parameter int RAM_WIDTH               = 16,
    parameter int ADDR_WIDTH              = 8,
    parameter int HEX_START_X             = 384,
    parameter int PIXELS_PER_HEX_DIGIT    = 16,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
    parameter int WORDS_PER_ROW           = 4,
    parameter int FONT_SCALE_LOG2         = 1
) (
    input  logic          CLK_50,
    input  logic          RESET,
    hex_word_drawer_if.master bus
);

    if (RAM_WIDTH != 16) begin : g_bad_width
        $error("hex_word_drawer: RAM_WIDTH must be 16 (four hex digits)");
    end

    localparam logic [9:0] X_FIRST   = 10'(HEX_START_X);
    localparam logic [9:0] X_END     = 10'(HEX_START_X + WORDS_PER_ROW * 4 * PIXELS_PER_HEX_DIGIT);
    localparam logic [9:0] Y_END     = 10'(HEX_AREA_MAX_Y);
    localparam logic [9:0] DIGIT_PX  = 10'(PIXELS_PER_HEX_DIGIT);
    localparam logic [9:0] WORD_PX   = 10'(4 * PIXELS_PER_HEX_DIGIT);
    localparam logic [9:0] ROW_PX    = 10'(1 << BITS_PER_MEMORY_PIXEL_Y);
    localparam logic [9:0] ROW_WORDS = 10'(WORDS_PER_ROW);

    // S0 decode
    logic                  in_hex_s;
    logic [9:0]            dx_s;
    logic [9:0]            word_col_s;
    logic [1:0]            digit_s;
    logic [2:0]            gx_s;
    logic [2:0]            gy_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic                  hl_s;
    logic                  rd_req_s;

    // S1 registers
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_en_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  word_valid_q;
    hex_pipe_t             s1_q;

    // S2 registers and lookup
    hex_pipe_t             s2_q;
    logic                  rd_d2_q;
    logic [RAM_WIDTH-1:0]  word_q;
    logic [RAM_WIDTH-1:0]  word_cur;
    logic [3:0]            nibble;
    logic [7:0]            glyph_row;
    logic                  pix_on;

    // S3 output stage
    logic                  req_d, req_q;
    rgb332_t               rgb_d, rgb_q;

    // Map the current pixel to word address, digit and glyph coordinates.
    always_comb begin
        in_hex_s   = (bus.pixel_x >= X_FIRST) && (bus.pixel_x < X_END) && (bus.pixel_y < Y_END);
        dx_s       = in_hex_s ? (bus.pixel_x - X_FIRST) : 10'd0;
        word_col_s = dx_s / WORD_PX;
        digit_s    = 2'(dx_s / DIGIT_PX);
        gx_s       = 3'((dx_s % DIGIT_PX) >> FONT_SCALE_LOG2);
        gy_s       = 3'((bus.pixel_y % ROW_PX) >> FONT_SCALE_LOG2);
        addr_s     = ADDR_WIDTH'((bus.pixel_y >> BITS_PER_MEMORY_PIXEL_Y) * ROW_WORDS + word_col_s);
        // The RAM port is shared with CPU writes, so only fetch when the word changes.
        rd_req_s   = in_hex_s && (!word_valid_q || (addr_s != last_addr_q));
    end

`ifdef HEX_DRAWER_HIGHLIGHT_EN
    // Cursor compare happens alongside the address so it can ride the pipe.
    always_comb begin
        hl_s = in_hex_s && (addr_s == bus.cursor_addr);
    end
`else
    // No highlight: cursor_addr may be left unconnected.
    always_comb begin
        hl_s = 1'b0;
    end
    logic unused_cursor;
    assign unused_cursor = ^bus.cursor_addr ^ s2_q.hl;
`endif

    // S1: register the read request and remember which word is held.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            mem_addr_q   <= '0;
            mem_rd_en_q  <= 1'b0;
            last_addr_q  <= '0;
            word_valid_q <= 1'b0;
            s1_q         <= '0;
        end else begin
            mem_addr_q  <= addr_s;
            mem_rd_en_q <= rd_req_s;
            if (rd_req_s) begin
                last_addr_q  <= addr_s;
                word_valid_q <= 1'b1;
            end
            s1_q <= '{in_hex: in_hex_s, digit: digit_s, gx: gx_s, gy: gy_s, hl: hl_s};
        end
    end

    // S2: hold the fetched word; a fresh read is used straight off the RAM bus.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            s2_q    <= '0;
            rd_d2_q <= 1'b0;
            word_q  <= '0;
        end else begin
            s2_q    <= s1_q;
            rd_d2_q <= mem_rd_en_q;
            word_q  <= word_cur;
        end
    end

    // Digit 0 is the most significant nibble; glyph column 0 sits in bit 7.
    always_comb begin
        word_cur = rd_d2_q ? bus.mem_rd_data : word_q;
        nibble   = word_cur[{~s2_q.digit, 2'b00} +: 4];
        pix_on   = glyph_row[~s2_q.gx];
    end

    hex_font_rom u_font (
        .nibble_i   (nibble),
        .row_i      (s2_q.gy),
        .row_bits_o (glyph_row)
    );

    // Colour decision for the output register.
    always_comb begin
        req_d = s2_q.in_hex && pix_on;
        rgb_d = req_d ? HEX_FG_RGB : 8'h00;
`ifdef HEX_DRAWER_HIGHLIGHT_EN
        if (s2_q.hl) begin
            req_d = s2_q.in_hex;
            rgb_d = pix_on ? 8'h00 : HEX_HL_RGB;
        end
`endif
    end

    // S3: registered outputs to the colour mux.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            req_q <= 1'b0;
            rgb_q <= 8'h00;
        end else begin
            req_q <= req_d;
            rgb_q <= rgb_d;
        end
    end

    assign bus.mem_addr               = mem_addr_q;
    assign bus.mem_rd_en              = mem_rd_en_q;
    assign bus.number_drawing_request = req_q;
    assign bus.number_rgb             = rgb_q;

endmodule
